// File: rtl/conv2_kernel_mac.sv
// conv2_kernel_mac
// Computes one signed fixed-point dot product between a stream of activation
// pairs and a kernel held in an external dual-port weight ROM. Weights are
// fetched two per cycle (even/odd tap). The products are summed in a wide
// accumulator, and the result is rescaled and saturated to 16 bits.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   start, kern_sel     : begin a dot product on kernel kern_sel (IDLE only)
//   act_valid/act_ready : activation-pair stream handshake
//   act_a, act_b        : signed activations for the even/odd tap of a pair
//   rom_address_a/_b    : weight ROM addresses (ROM has 1-cycle read latency)
//   rom_q_a, rom_q_b    : signed weights returned by the ROM
//   res_valid/res_ready : result handshake
//   res_data            : signed, saturated result
//   busy                : high whenever the block is not idle
module conv2_kernel_mac #(
  parameter int KLEN = 50,
  parameter int FRAC = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  kern_sel,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [15:0] act_a,
  input  logic [15:0] act_b,
  output logic [7:0]  rom_address_a,
  output logic [7:0]  rom_address_b,
  input  logic [15:0] rom_q_a,
  input  logic [15:0] rom_q_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy
);

  localparam logic [7:0] LAST_PAIR = 8'(KLEN / 2 - 1);
  // Only the low 8 bits of kern_sel*KLEN are kept, so KLEN mod 256 suffices.
  localparam logic [7:0] KLEN8 = 8'(KLEN % 256);
  localparam logic signed [39:0] RES_MAX = 40'sd32767;
  localparam logic signed [39:0] RES_MIN = -40'sd32768;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [7:0]         base;
  logic [7:0]         p;
  logic               s1_valid;
  logic signed [15:0] s1_a, s1_b;
  logic signed [39:0] acc;

  logic               start_ok;
  logic               act_hs;
  logic [7:0]         base_next;
  logic [7:0]         pair_off;
  logic signed [31:0] prod_a, prod_b;
  logic signed [39:0] acc_scaled;

  assign start_ok  = (state == IDLE) && start;
  assign act_ready = (state == RUN);
  assign act_hs    = act_valid && act_ready;
  assign base_next = kern_sel * KLEN8;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  // Addresses come straight from the base and pair registers; since the ROM
  // samples them on the handshake edge, its output lines up with stage 1.
  assign pair_off      = {p[6:0], 1'b0};
  assign rom_address_a = base + pair_off;
  assign rom_address_b = base + pair_off + 8'd1;

  // Sign-extend before multiplying; the 32-bit truncation is exact because a
  // 16x16 signed product always fits in 32 bits.
  assign prod_a = 32'(s1_a) * 32'($signed(rom_q_a));
  assign prod_b = 32'(s1_b) * 32'($signed(rom_q_b));

  // Rescale and saturate from the accumulator register, so the result is
  // stable for as long as the block sits in DONE.
  always_comb begin
    acc_scaled = acc >>> FRAC;
    if (acc_scaled > RES_MAX) begin
      res_data = 16'h7FFF;
    end else if (acc_scaled < RES_MIN) begin
      res_data = 16'h8000;
    end else begin
      res_data = acc_scaled[15:0];
    end
  end

  // Next-state logic. DRAIN is the single cycle in which the last pair
  // (captured at the final handshake) is folded into the accumulator.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (act_hs && (p == LAST_PAIR)) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, pair counter, stage-1 activation registers and accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      base     <= 8'd0;
      p        <= 8'd0;
      s1_valid <= 1'b0;
      s1_a     <= 16'sd0;
      s1_b     <= 16'sd0;
      acc      <= 40'sd0;
    end else begin
      state    <= state_next;
      s1_valid <= act_hs;
      if (start_ok) begin
        base <= base_next;
        p    <= 8'd0;
        acc  <= 40'sd0;
      end else if (s1_valid) begin
        acc <= acc + 40'(prod_a) + 40'(prod_b);
      end
      if (act_hs) begin
        s1_a <= act_a;
        s1_b <= act_b;
        p    <= p + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv2_kernel_mac.sv
// Directed bench for conv2_kernel_mac: two instances (KLEN=50 and KLEN=52)
// each fed by its own registered read port of a shared 256x16 weight array.
module tb_conv2_kernel_mac;

  typedef struct {
    int         pair;
    logic [7:0] a;
    logic [7:0] b;
  } samp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  kern_sel = 8'd0;
  logic        act_valid = 1'b0;
  logic [15:0] act_a = 16'd0;
  logic [15:0] act_b = 16'd0;
  logic        res_ready = 1'b1;

  logic        d0_act_ready, d0_res_valid, d0_busy;
  logic [7:0]  d0_addr_a, d0_addr_b;
  logic [15:0] d0_q_a, d0_q_b, d0_res_data;
  logic        d1_act_ready, d1_res_valid, d1_busy;
  logic [7:0]  d1_addr_a, d1_addr_b;
  logic [15:0] d1_q_a, d1_q_b, d1_res_data;

  logic [15:0] rom [256];
  logic [15:0] act_a_vec [32];
  logic [15:0] act_b_vec [32];
  samp_t       samp_q [$];

  logic        use52 = 1'b0;
  logic        obs_ready, obs_res_valid;
  logic [7:0]  obs_addr_a, obs_addr_b;
  logic [15:0] obs_res_data;

  int cycle = 0;
  int checks = 0;
  int failures = 0;

  conv2_kernel_mac #(.KLEN(50), .FRAC(8)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .kern_sel(kern_sel),
    .act_valid(act_valid), .act_ready(d0_act_ready),
    .act_a(act_a), .act_b(act_b),
    .rom_address_a(d0_addr_a), .rom_address_b(d0_addr_b),
    .rom_q_a(d0_q_a), .rom_q_b(d0_q_b),
    .res_valid(d0_res_valid), .res_ready(res_ready),
    .res_data(d0_res_data), .busy(d0_busy)
  );

  conv2_kernel_mac #(.KLEN(52), .FRAC(8)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .kern_sel(kern_sel),
    .act_valid(act_valid), .act_ready(d1_act_ready),
    .act_a(act_a), .act_b(act_b),
    .rom_address_a(d1_addr_a), .rom_address_b(d1_addr_b),
    .rom_q_a(d1_q_a), .rom_q_b(d1_q_b),
    .res_valid(d1_res_valid), .res_ready(res_ready),
    .res_data(d1_res_data), .busy(d1_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cycle  <= cycle + 1;
    d0_q_a <= rom[d0_addr_a];
    d0_q_b <= rom[d0_addr_b];
    d1_q_a <= rom[d1_addr_a];
    d1_q_b <= rom[d1_addr_b];
  end

  assign obs_ready     = use52 ? d1_act_ready : d0_act_ready;
  assign obs_res_valid = use52 ? d1_res_valid : d0_res_valid;
  assign obs_res_data  = use52 ? d1_res_data  : d0_res_data;
  assign obs_addr_a    = use52 ? d1_addr_a    : d0_addr_a;
  assign obs_addr_b    = use52 ? d1_addr_b    : d0_addr_b;

  // Reference dot product: Q8 weights/acts, floor shift, 16-bit saturation.
  function automatic logic [15:0] model_dot(input int ks, input int klen);
    longint acc;
    longint sh;
    int     base;
    int     ia;
    acc  = 0;
    base = (ks * klen) % 256;
    for (int i = 0; i < klen / 2; i++) begin
      ia  = (base + 2 * i) % 256;
      acc = acc + longint'($signed(act_a_vec[i])) * longint'($signed(rom[ia]))
                + longint'($signed(act_b_vec[i])) * longint'($signed(rom[(ia + 1) % 256]));
    end
    sh = acc >>> 8;
    if (sh > 32767) return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
    return 16'(sh);
  endfunction

  task automatic fill_const(input logic [15:0] w, input logic [15:0] a);
    for (int i = 0; i < 256; i++) rom[i] = w;
    for (int i = 0; i < 32; i++) begin
      act_a_vec[i] = a;
      act_b_vec[i] = a;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 32; i++) begin
      act_a_vec[i] = 16'($urandom);
      act_b_vec[i] = 16'($urandom);
    end
  endtask

  // Called at a negedge. Pulses start, streams pairs with act_valid high every
  // 'period' cycles, logs addresses on every RUN cycle and returns at the
  // negedge where res_valid is first seen.
  task automatic run_dot(input logic [7:0] ks, input int period,
                         output logic [15:0] res, output int latency);
    int  pair;
    int  k;
    int  npairs;
    int  start_cyc;
    bit  got;
    npairs = use52 ? 26 : 25;
    samp_q.delete();
    kern_sel  = ks;
    start0    = !use52;
    start1    = use52;
    act_valid = (period == 1);
    act_a     = act_a_vec[0];
    act_b     = act_b_vec[0];
    start_cyc = cycle;
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
    pair = 0;
    k = 0;
    got = 0;
    res = 16'd0;
    latency = -1;
    for (int w = 0; w < 1000 && !got; w++) begin
      if (obs_res_valid) begin
        got = 1;
        res = obs_res_data;
        latency = cycle - start_cyc;
        act_valid = 1'b0;
      end else begin
        if (obs_ready) samp_q.push_back('{pair: pair, a: obs_addr_a, b: obs_addr_b});
        act_valid = (pair < npairs) && (k % period == 0);
        act_a = act_a_vec[pair % 32];
        act_b = act_b_vec[pair % 32];
        if (act_valid && obs_ready) pair++;
        k++;
        @(negedge clock);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL run_timeout: res_valid=0 after 1000 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start0 = 1'b1;
    act_valid = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clock);
    checks += 8;
    if (d0_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", d0_busy); end
    if (d0_act_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b want 0", d0_act_ready); end
    if (d0_res_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid: got %b want 0", d0_res_valid); end
    if (d0_addr_a !== 8'd0) begin failures++; $display("[TB] FAIL reset_addr_a: got %0d want 0", d0_addr_a); end
    if (d0_addr_b !== 8'd1) begin failures++; $display("[TB] FAIL reset_addr_b: got %0d want 1", d0_addr_b); end
    if (d0_res_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_res_data: got %h want 0000", d0_res_data); end
    if (d1_addr_a !== 8'd0) begin failures++; $display("[TB] FAIL reset_addr_a_52: got %0d want 0", d1_addr_a); end
    if (d1_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_52: got %b want 0", d1_busy); end
    reset = 1'b0;
    start0 = 1'b0;
    act_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (d0_busy !== 1'b0 || d0_addr_b !== 8'd1) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: busy=%b addr_b=%0d want 0/1", d0_busy, d0_addr_b);
    end
  endtask

  task automatic test_unity();
    logic [15:0] res;
    int lat;
    use52 = 1'b0;
    fill_const(16'h0100, 16'h0100);
    run_dot(8'd0, 1, res, lat);
    checks += 4;
    if (res !== 16'h3200) begin failures++; $display("[TB] FAIL unity_res: got %h want 3200", res); end
    if (lat !== 27) begin failures++; $display("[TB] FAIL unity_latency: got %0d want 27", lat); end
    if (samp_q.size() !== 25) begin failures++; $display("[TB] FAIL unity_nsamples: got %0d want 25", samp_q.size()); end
    if (res !== model_dot(0, 50)) begin failures++; $display("[TB] FAIL unity_model: got %h want %h", res, model_dot(0, 50)); end
    foreach (samp_q[i]) begin
      checks++;
      if (samp_q[i].a !== 8'(2 * samp_q[i].pair) || samp_q[i].b !== 8'(2 * samp_q[i].pair + 1)) begin
        failures++;
        $display("[TB] FAIL unity_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, samp_q[i].a,
                 samp_q[i].b, 2 * samp_q[i].pair, 2 * samp_q[i].pair + 1);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_sign_offset();
    logic [15:0] res;
    int lat;
    use52 = 1'b0;
    fill_const(16'h0100, 16'h0100);
    for (int i = 50; i < 100; i++) rom[i] = 16'hFF00;
    run_dot(8'd1, 1, res, lat);
    checks += 2;
    if (res !== 16'hCE00) begin failures++; $display("[TB] FAIL sign_res: got %h want CE00", res); end
    if (samp_q.size() == 0 || samp_q[0].a !== 8'd50 || samp_q[0].b !== 8'd51) begin
      failures++;
      $display("[TB] FAIL sign_first_addr: first address pair wrong, want (50,51)");
    end
    foreach (samp_q[i]) begin
      checks++;
      if (samp_q[i].a !== 8'(50 + 2 * samp_q[i].pair)) begin
        failures++;
        $display("[TB] FAIL sign_addr[%0d]: got %0d want %0d", i, samp_q[i].a, 50 + 2 * samp_q[i].pair);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_saturation();
    logic [15:0] res;
    int lat;
    use52 = 1'b0;
    fill_const(16'h7FFF, 16'h7FFF);
    run_dot(8'd0, 1, res, lat);
    checks++;
    if (res !== 16'h7FFF) begin failures++; $display("[TB] FAIL sat_pos: got %h want 7FFF", res); end
    @(negedge clock);
    fill_const(16'h8000, 16'h7FFF);
    run_dot(8'd2, 1, res, lat);
    checks++;
    if (res !== 16'h8000) begin failures++; $display("[TB] FAIL sat_neg: got %h want 8000", res); end
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    use52 = 1'b0;
    fill_random();
    exp = model_dot(3, 50);
    run_dot(8'd3, 3, res, lat);
    checks += 3;
    if (res !== exp) begin failures++; $display("[TB] FAIL bp_res: got %h want %h", res, exp); end
    if (lat !== 75) begin failures++; $display("[TB] FAIL bp_latency: got %0d want 75", lat); end
    if (samp_q.size() !== 73) begin failures++; $display("[TB] FAIL bp_nsamples: got %0d want 73", samp_q.size()); end
    foreach (samp_q[i]) begin
      checks++;
      if (samp_q[i].a !== 8'(150 + 2 * samp_q[i].pair) || samp_q[i].b !== 8'(151 + 2 * samp_q[i].pair)) begin
        failures++;
        $display("[TB] FAIL bp_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, samp_q[i].a, samp_q[i].b,
                 (150 + 2 * samp_q[i].pair) % 256, (151 + 2 * samp_q[i].pair) % 256);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_res_stall();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    use52 = 1'b0;
    fill_random();
    exp = model_dot(3, 50);
    res_ready = 1'b0;
    run_dot(8'd3, 1, res, lat);
    checks++;
    if (res !== exp) begin failures++; $display("[TB] FAIL stall_res: got %h want %h", res, exp); end
    for (int i = 0; i < 10; i++) begin
      kern_sel = 8'd7;
      start0 = (i == 3);
      @(negedge clock);
      checks++;
      if (d0_res_valid !== 1'b1 || d0_res_data !== res || d0_busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b data=%h busy=%b want 1/%h/1", i,
                 d0_res_valid, d0_res_data, d0_busy, res);
      end
    end
    start0 = 1'b1;
    res_ready = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    checks += 2;
    if (d0_busy !== 1'b0 || d0_res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_start_on_hs: busy=%b valid=%b want 0/0", d0_busy, d0_res_valid);
    end
    if (d0_addr_a !== 8'd200) begin
      failures++;
      $display("[TB] FAIL stall_addr_kept: got %0d want 200", d0_addr_a);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    int pair;
    use52 = 1'b0;
    fill_random();
    kern_sel = 8'd2;
    start0 = 1'b1;
    act_valid = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    pair = 0;
    for (int w = 0; w < 100 && pair < 10; w++) begin
      act_a = act_a_vec[pair];
      act_b = act_b_vec[pair];
      if (d0_act_ready) pair++;
      @(negedge clock);
    end
    checks++;
    if (pair != 10) begin failures++; $display("[TB] FAIL midrun_reach: pairs=%0d want 10", pair); end
    reset = 1'b1;
    start0 = 1'b1;
    act_valid = 1'b1;
    @(negedge clock);
    checks += 3;
    if (d0_busy !== 1'b0 || d0_act_ready !== 1'b0 || d0_res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_ctrl: busy=%b ready=%b valid=%b want 0/0/0", d0_busy, d0_act_ready, d0_res_valid);
    end
    if (d0_addr_a !== 8'd0 || d0_addr_b !== 8'd1) begin
      failures++;
      $display("[TB] FAIL midrun_addr: got (%0d,%0d) want (0,1)", d0_addr_a, d0_addr_b);
    end
    if (d0_res_data !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midrun_res_data: got %h want 0000", d0_res_data);
    end
    reset = 1'b0;
    start0 = 1'b0;
    act_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (d0_busy !== 1'b0 || d0_addr_a !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midrun_idle: busy=%b addr_a=%0d want 0/0", d0_busy, d0_addr_a);
    end
    fill_random();
    exp = model_dot(2, 50);
    run_dot(8'd2, 1, res, lat);
    checks += 2;
    if (res !== exp) begin failures++; $display("[TB] FAIL midrun_rerun: got %h want %h", res, exp); end
    if (lat !== 27) begin failures++; $display("[TB] FAIL midrun_latency: got %0d want 27", lat); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    use52 = 1'b0;
    fill_random();
    res_ready = 1'b1;
    run_dot(8'd4, 1, res, lat);
    checks++;
    if (res !== model_dot(4, 50)) begin failures++; $display("[TB] FAIL b2b_first: got %h want %h", res, model_dot(4, 50)); end
    @(negedge clock);
    checks++;
    if (d0_busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: busy=%b want 0", d0_busy); end
    exp = model_dot(1, 50);
    run_dot(8'd1, 1, res, lat);
    checks += 2;
    if (res !== exp) begin failures++; $display("[TB] FAIL b2b_second: got %h want %h", res, exp); end
    if (lat !== 27) begin failures++; $display("[TB] FAIL b2b_latency: got %0d want 27", lat); end
    @(negedge clock);
  endtask

  task automatic test_wrap();
    logic [15:0] res;
    logic [15:0] exp;
    int lat;
    use52 = 1'b1;
    fill_random();
    exp = model_dot(5, 52);
    run_dot(8'd5, 1, res, lat);
    checks += 4;
    if (res !== exp) begin failures++; $display("[TB] FAIL wrap_res: got %h want %h", res, exp); end
    if (lat !== 28) begin failures++; $display("[TB] FAIL wrap_latency: got %0d want 28", lat); end
    if (samp_q.size() !== 26) begin failures++; $display("[TB] FAIL wrap_nsamples: got %0d want 26", samp_q.size()); end
    if (samp_q.size() == 0 || samp_q[$].a !== 8'd54 || samp_q[$].b !== 8'd55) begin
      failures++;
      $display("[TB] FAIL wrap_last_addr: last address pair wrong, want (54,55)");
    end
    foreach (samp_q[i]) begin
      checks++;
      if (samp_q[i].a !== 8'(4 + 2 * samp_q[i].pair) || samp_q[i].b !== 8'(5 + 2 * samp_q[i].pair)) begin
        failures++;
        $display("[TB] FAIL wrap_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, samp_q[i].a, samp_q[i].b,
                 4 + 2 * samp_q[i].pair, 5 + 2 * samp_q[i].pair);
      end
    end
    @(negedge clock);
    checks++;
    if (d1_busy !== 1'b0) begin failures++; $display("[TB] FAIL wrap_idle: busy=%b want 0", d1_busy); end
    use52 = 1'b0;
  endtask

  initial begin
    fill_const(16'h0000, 16'h0000);
    test_reset();
    test_unity();
    test_sign_offset();
    test_saturation();
    test_backpressure();
    test_res_stall();
    test_reset_midrun();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
